adder_resp_checker: RTL and testbench
=====================================

Name: adder_resp_checker

Overview:
- Hardware response checker for the 4-bit adder data path; it sits at the far end of the adder interface, opposite the stimulus source.
- Accepts operand pairs as they are issued to the adder and computes the golden sum for each.
- Queues the golden sums in order, then compares each returned adder result against the head of the queue.
- Keeps pass/error statistics and captures the first mismatch, so regressions are self-checking without waveform inspection.

Parameters:
- WIDTH, 4, operand width; the sum is WIDTH+1 bits.
- DEPTH, 4, number of golden-sum entries that can be outstanding; must be a power of two, at least 2.
- CNT_W, 8, width of the check and error counters.
- STOP_ON_ERR, 0, if 1 the checker halts at the first mismatch or orphan result.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  operand pair is being issued to the adder this cycle
- op_a  in  WIDTH  operand a
- op_b  in  WIDTH  operand b
- op_ready  out  1  checker can accept an operand pair
- res_valid  in  1  an adder result is presented this cycle
- res_sum  in  WIDTH+1  adder result
- chk_count  out  CNT_W  number of results compared
- err_count  out  CNT_W  number of mismatches plus orphan results
- err_flag  out  1  sticky; set by any error
- orphan_flag  out  1  sticky; set when a result arrives with the queue empty
- fail_exp  out  WIDTH+1  expected sum at the first mismatch
- fail_got  out  WIDTH+1  received sum at the first mismatch
- halted  out  1  checker is in the HALT state

Behaviour:
- Reset:
  - All outputs go to 0 except op_ready, which goes to 1.
  - The queue is emptied and the state returns to RUN.
  - Reset asserted mid-operation discards all outstanding entries in the same cycle.
- Push:
  - Fires when op_valid && op_ready.
  - Writes the zero-extended sum a+b (WIDTH+1 bits, carry kept, no truncation) to the queue tail.
- Ready rules:
  - In RUN, op_ready = !full, registered.
  - A pop in the same cycle does not free a slot for a push when the queue is full.
  - If op_valid arrives while op_ready=0, it is ignored and not counted; the stimulus side must hold off.
- Pop and compare:
  - res_valid with the queue non-empty pops the head and compares it with res_sum.
  - chk_count increments on every compare.
  - On mismatch: err_count increments and err_flag is set. fail_exp and fail_got are captured only when err_flag was 0 beforehand; later errors do not overwrite them.
- Orphan result:
  - res_valid with the queue empty, including the cycle of a push into an empty queue, counts as an error.
  - It increments err_count and sets both orphan_flag and err_flag. It does not increment chk_count.
  - Minimum adder latency is therefore 1 cycle.
- Simultaneous push and pop with the queue neither full nor empty: both occur and the occupancy is unchanged.
- Pointers: wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.
- Counters: saturate at all-ones and never wrap.
- Output timing: all statistic outputs are registered and update the cycle after the triggering event.
- State machine:
  - RUN → HALT on the first error when STOP_ON_ERR=1. HALT → RUN only through rst.
  - In HALT, op_ready=0, halted=1, res_valid is ignored and all counters freeze.
  - With STOP_ON_ERR=0 the checker never leaves RUN.

Decomposition:
- Package adder_chk_pkg holds:
  - the state enum {RUN, HALT};
  - the default constants WIDTH, DEPTH and CNT_W;
  - the function golden_sum(a, b) returning WIDTH+1 bits.
- One sub-module, adder_chk_fifo: a synchronous FIFO on clk/rst with push, pop, full, empty and DEPTH entries of WIDTH+1 bits.
- adder_resp_checker contains the compare logic, counters, capture registers and state machine.

Test Plan:
- Matching sums: push (0,0), (1,1), (6,3), (15,1), (10,5), (15,15); return 0, 2, 9, 16, 15, 30 one cycle later each → chk_count=6, err_count=0, err_flag=0.
- Carry retention: push (15,15), return 5'b11110 → pass. Return 5'b01110 → err_flag=1, fail_exp=30, fail_got=14.
- Full queue: push 4 pairs with no results → op_ready=0. Drive op_valid with (1,1) → not queued. Pop one → op_ready=1 the next cycle, and the remaining 3 results compare in order.
- Orphan result: after reset, res_valid with res_sum=3 and an empty queue → orphan_flag=1, err_count=1, chk_count=0.
- Stop on error: STOP_ON_ERR=1, push (6,3), return 8 → halted=1, op_ready=0. Further results leave chk_count=1 and err_count=1. rst → all outputs cleared, op_ready=1.
- Reset with 3 entries outstanding → queue empty; a following res_valid counts as an orphan.

Source files
------------

// File: rtl/adder_chk_pkg.sv
// Shared types and defaults for the 4-bit adder response checker.
// Holds the checker state encoding and the golden-sum helper.
package adder_chk_pkg;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // Zero-extended sum with the carry kept in the top bit.
  function automatic logic [WIDTH:0] golden_sum(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/adder_chk_fifo.sv
// Golden-sum queue: synchronous FIFO, DEPTH entries of DW bits.
// Ports: clk, rst, push/din, pop/dout, full, empty, full_nxt.
module adder_chk_fifo #(
  parameter int DW    = 5,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          full_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] wptr_n, rptr_n;
  logic          do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  assign wptr_n = do_push ? wptr + PW'(1) : wptr;
  assign rptr_n = do_pop  ? rptr + PW'(1) : rptr;

  // Occupancy after this edge; lets the owner register a ready flag.
  assign full_nxt = (wptr_n[AW] != rptr_n[AW]) &&
                    (wptr_n[AW-1:0] == rptr_n[AW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adder_resp_checker.sv
// Response checker for the adder path: queues golden sums, compares results.
// Ports: op_* (issued operands), res_* (adder results), statistics, halted.
module adder_resp_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH       = adder_chk_pkg::WIDTH,
  parameter int DEPTH       = adder_chk_pkg::DEPTH,
  parameter int CNT_W       = adder_chk_pkg::CNT_W,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             op_ready,
  input  logic             res_valid,
  input  logic [WIDTH:0]   res_sum,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic             orphan_flag,
  output logic [WIDTH:0]   fail_exp,
  output logic [WIDTH:0]   fail_got,
  output logic             halted
);

  state_t         state, state_n;
  logic           run;
  logic           push, pop;
  logic           full, empty, full_nxt;
  logic [WIDTH:0] head, gsum;
  logic           mismatch, orphan, err_ev;

  assign run  = (state == RUN);
  assign gsum = golden_sum(op_a, op_b);
  assign push = op_valid && op_ready;
  assign pop  = run && res_valid && !empty;

  // Orphan uses pre-push emptiness: a same-cycle push cannot satisfy it.
  assign mismatch = pop && (head != res_sum);
  assign orphan   = run && res_valid && empty;
  assign err_ev   = mismatch || orphan;

  adder_chk_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (gsum),
    .pop      (pop),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .full_nxt (full_nxt)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      RUN:  if (STOP_ON_ERR && err_ev) state_n = HALT;
      HALT: state_n = HALT;
      default: state_n = RUN;
    endcase
  end

  assign halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      op_ready    <= 1'b1;
      chk_count   <= '0;
      err_count   <= '0;
      err_flag    <= 1'b0;
      orphan_flag <= 1'b0;
      fail_exp    <= '0;
      fail_got    <= '0;
    end else begin
      state    <= state_n;
      op_ready <= (state_n == RUN) && !full_nxt;
      if (pop && chk_count != '1)
        chk_count <= chk_count + CNT_W'(1);
      if (err_ev && err_count != '1)
        err_count <= err_count + CNT_W'(1);
      if (err_ev) err_flag <= 1'b1;
      if (orphan) orphan_flag <= 1'b1;
      if (mismatch && !err_flag) begin
        fail_exp <= head;
        fail_got <= res_sum;
      end
    end
  end

endmodule

// File: tb/tb_adder_resp_checker.sv
// Self-checking bench for adder_resp_checker against a queue-based model.
// Covers directed plan items plus a long randomized phase with saturation.
module tb_adder_resp_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [3:0] op_a, op_b;
  logic       res_valid;
  logic [4:0] res_sum;

  logic       op_ready, err_flag, orphan_flag, halted;
  logic [7:0] chk_count, err_count;
  logic [4:0] fail_exp, fail_got;

  logic       h_ready, h_err_flag, h_orph, h_halted;
  logic [7:0] h_chk, h_err;
  logic [4:0] h_fexp, h_fgot;

  always #5 clk = ~clk;

  adder_resp_checker #(.STOP_ON_ERR(1'b0)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .op_ready(op_ready),
    .res_valid(res_valid), .res_sum(res_sum),
    .chk_count(chk_count), .err_count(err_count),
    .err_flag(err_flag), .orphan_flag(orphan_flag),
    .fail_exp(fail_exp), .fail_got(fail_got),
    .halted(halted)
  );

  adder_resp_checker #(.STOP_ON_ERR(1'b1)) dut_h (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .op_ready(h_ready),
    .res_valid(res_valid), .res_sum(res_sum),
    .chk_count(h_chk), .err_count(h_err),
    .err_flag(h_err_flag), .orphan_flag(h_orph),
    .fail_exp(h_fexp), .fail_got(h_fgot),
    .halted(h_halted)
  );

  int errors = 0;
  int checks = 0;

  // Reference model for the STOP_ON_ERR=0 instance.
  logic [4:0] mq[$];
  int         m_chk, m_err;
  bit         m_eflag, m_orph, m_ready;
  logic [4:0] m_fexp, m_fgot;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_chk = 0; m_err = 0;
    m_eflag = 0; m_orph = 0; m_ready = 1;
    m_fexp = '0; m_fgot = '0;
  endtask

  task automatic check_all();
    check("op_ready",    32'(op_ready),    32'(m_ready));
    check("chk_count",   32'(chk_count),   32'(m_chk));
    check("err_count",   32'(err_count),   32'(m_err));
    check("err_flag",    32'(err_flag),    32'(m_eflag));
    check("orphan_flag", 32'(orphan_flag), 32'(m_orph));
    check("fail_exp",    32'(fail_exp),    32'(m_fexp));
    check("fail_got",    32'(fail_got),    32'(m_fgot));
    check("halted",      32'(halted),      32'(0));
  endtask

  task automatic step(input bit v, input int a, input int b,
                      input bit rv, input int rs);
    bit         rdy;
    logic [4:0] e;
    op_valid  = v;
    op_a      = 4'(a);
    op_b      = 4'(b);
    res_valid = rv;
    res_sum   = 5'(rs);
    rdy       = m_ready;
    @(posedge clk);
    if (rv) begin
      if (mq.size() == 0) begin
        m_orph = 1;
        if (m_err < 255) m_err++;
        m_eflag = 1;
      end else begin
        e = mq.pop_front();
        if (m_chk < 255) m_chk++;
        if (e != 5'(rs)) begin
          if (!m_eflag) begin
            m_fexp = e;
            m_fgot = 5'(rs);
          end
          if (m_err < 255) m_err++;
          m_eflag = 1;
        end
      end
    end
    if (v && rdy) mq.push_back(5'(a + b));
    m_ready = (mq.size() < 4);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_valid = 0; op_a = 0; op_b = 0;
    res_valid = 0; res_sum = 0;
    @(posedge clk);
    model_clear();
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    bit v, rv;
    int a, b, rs;

    // Reset state
    do_reset();

    // Matching sums, each returned one cycle after issue
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    step(1, 6, 3, 1, 2);
    step(1, 15, 1, 1, 9);
    step(1, 10, 5, 1, 16);
    step(1, 15, 15, 1, 15);
    step(0, 0, 0, 1, 30);
    check("match_chk6", 32'(chk_count), 32'd6);
    check("match_err0", 32'(err_count), 32'd0);

    // Carry retention
    step(1, 15, 15, 0, 0);
    step(0, 0, 0, 1, 5'b11110);
    check("carry_pass", 32'(err_flag), 32'd0);
    step(1, 15, 15, 0, 0);
    step(0, 0, 0, 1, 5'b01110);
    check("carry_eflag", 32'(err_flag), 32'd1);
    check("carry_fexp",  32'(fail_exp), 32'd30);
    check("carry_fgot",  32'(fail_got), 32'd14);
    // A later mismatch must not overwrite the capture
    step(1, 1, 2, 0, 0);
    step(0, 0, 0, 1, 7);
    check("capture_hold", 32'(fail_got), 32'd14);

    // Full queue; blocked push ignored; pop reopens ready
    do_reset();
    step(1, 2, 3, 0, 0);
    step(1, 4, 4, 0, 0);
    step(1, 7, 8, 0, 0);
    step(1, 9, 1, 0, 0);
    check("full_ready0", 32'(op_ready), 32'd0);
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 5);
    check("pop_ready1", 32'(op_ready), 32'd1);
    step(0, 0, 0, 1, 8);
    step(0, 0, 0, 1, 15);
    step(0, 0, 0, 1, 10);
    check("full_err0", 32'(err_count), 32'd0);
    // Nothing left: the blocked (1,1) was not queued
    step(0, 0, 0, 1, 2);
    check("full_orphan", 32'(orphan_flag), 32'd1);

    // Orphan after reset
    do_reset();
    step(0, 0, 0, 1, 3);
    check("orph_flag", 32'(orphan_flag), 32'd1);
    check("orph_err",  32'(err_count),   32'd1);
    check("orph_chk",  32'(chk_count),   32'd0);
    // Push into empty queue with a same-cycle result is an orphan
    step(1, 1, 2, 1, 3);
    check("orph_same", 32'(err_count), 32'd2);
    step(0, 0, 0, 1, 3);

    // Stop on error (second instance)
    do_reset();
    check("h_rst_ready", 32'(h_ready), 32'd1);
    step(1, 6, 3, 0, 0);
    step(0, 0, 0, 1, 8);
    check("h_halted", 32'(h_halted), 32'd1);
    check("h_ready0", 32'(h_ready),  32'd0);
    check("h_fexp",   32'(h_fexp),   32'd9);
    check("h_fgot",   32'(h_fgot),   32'd8);
    step(1, 2, 2, 0, 0);
    step(0, 0, 0, 1, 4);
    step(0, 0, 0, 1, 9);
    check("h_chk1", 32'(h_chk), 32'd1);
    check("h_err1", 32'(h_err), 32'd1);
    check("h_still", 32'(h_halted), 32'd1);
    do_reset();
    check("h_rst_halt", 32'(h_halted),   32'd0);
    check("h_rst_chk",  32'(h_chk),      32'd0);
    check("h_rst_err",  32'(h_err),      32'd0);
    check("h_rst_ef",   32'(h_err_flag), 32'd0);
    check("h_rst_orph", 32'(h_orph),     32'd0);
    check("h_rst_fexp", 32'(h_fexp),     32'd0);
    check("h_rst_rdy",  32'(h_ready),    32'd1);

    // Reset with 3 entries outstanding
    step(1, 1, 1, 0, 0);
    step(1, 2, 2, 0, 0);
    step(1, 3, 3, 0, 0);
    do_reset();
    step(0, 0, 0, 1, 2);
    check("rst_flush_orph", 32'(orphan_flag), 32'd1);
    check("rst_flush_chk",  32'(chk_count),   32'd0);

    // Randomized traffic; long enough to saturate both counters
    do_reset();
    for (int i = 0; i < 900; i++) begin
      v  = bit'($urandom_range(0, 1));
      a  = int'($urandom_range(0, 15));
      b  = int'($urandom_range(0, 15));
      rv = ($urandom_range(0, 9) < 6);
      if (mq.size() != 0 && $urandom_range(0, 1) == 1)
        rs = int'(mq[0]);
      else
        rs = int'($urandom_range(0, 31));
      step(v, a, b, rv, rs);
    end
    check("sat_chk", 32'(chk_count), 32'd255);
    check("sat_err", 32'(err_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
